// File: rtl/vga_frame_checker.sv
// vga_frame_checker: pixel-clock receiver for the VGA sink side.
// Measures line length, hs/vs pulse widths and lines per frame, checks them
// against the expected timing, keeps a per-frame RGB checksum and reports lock.
module vga_frame_checker #(
  parameter int unsigned HOR_TOTAL      = 1344,
  parameter int unsigned VER_TOTAL      = 806,
  parameter int unsigned HOR_SYNC_WIDTH = 136,
  parameter int unsigned VER_SYNC_WIDTH = 6,
  parameter logic        SYNC_ACTIVE    = 1'b1,
  parameter int unsigned LOCK_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [11:0] line_len,
  output logic [11:0] hs_width,
  output logic [10:0] frame_lines,
  output logic [10:0] vs_width,
  output logic [23:0] checksum,
  output logic        frame_done,
  output logic        locked,
  output logic        err_h,
  output logic        err_v
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;

  localparam logic [11:0] HT_C   = 12'(HOR_TOTAL);
  localparam logic [11:0] HSW_C  = 12'(HOR_SYNC_WIDTH);
  localparam logic [10:0] VT_C   = 11'(VER_TOTAL);
  localparam logic [10:0] VSW_C  = 11'(VER_SYNC_WIDTH);
  localparam logic [4:0]  LOCK_C = 5'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic        hs_seen_q, hs_seen_d, vs_seen_q, vs_seen_d, hw_vld_q, hw_vld_d;
  logic [11:0] hcnt_q, hcnt_d, hwcnt_q, hwcnt_d;
  logic [11:0] line_len_q, line_len_d, hs_width_q, hs_width_d;
  logic [10:0] lcnt_q, lcnt_d, vcnt_q, vcnt_d;
  logic [10:0] frame_lines_q, frame_lines_d, vs_width_q, vs_width_d;
  logic [23:0] acc_q, acc_d, checksum_q, checksum_d;
  logic [3:0]  match_q, match_d;
  logic        bad_q, bad_d, fd_q, fd_d, err_h_q, err_h_d, err_v_q, err_v_d;

  // Polarity-normalised syncs and their edges
  logic hs_a, vs_a, hs_rise, hs_fall, vs_rise, vs_fall, chk_en, h_mis, v_mis;
  assign hs_a    = (hs == SYNC_ACTIVE);
  assign vs_a    = (vs == SYNC_ACTIVE);
  assign hs_rise = hs_a & ~hs_prev_q;
  assign hs_fall = ~hs_a & hs_prev_q;
  assign vs_rise = vs_a & ~vs_prev_q;
  assign vs_fall = ~vs_a & vs_prev_q;

  // Checks only once a full frame boundary has been seen; horizontal checks
  // also need a previous edge and a completed hs pulse to compare against.
  assign chk_en = (state_q != SEARCH);
  assign h_mis  = chk_en & hs_rise & hs_seen_q & hw_vld_q &
                  ((hcnt_q != HT_C) | (hs_width_q != HSW_C));
  assign v_mis  = chk_en & vs_rise & ((lcnt_q != VT_C) | (vs_width_q != VSW_C));

  // Measurement datapath: counters, capture registers, checksum accumulator
  always_comb begin
    hs_seen_d     = hs_seen_q | hs_rise;
    vs_seen_d     = vs_seen_q | vs_rise;
    hcnt_d        = hs_rise ? 12'd1 : ((hcnt_q == '1) ? hcnt_q : hcnt_q + 12'd1);
    hwcnt_d       = hwcnt_q;
    if (hs_rise)                     hwcnt_d = 12'd1;
    else if (hs_a && hwcnt_q != '1)  hwcnt_d = hwcnt_q + 12'd1;
    line_len_d    = (hs_rise & hs_seen_q) ? hcnt_q : line_len_q;
    hs_width_d    = (hs_fall & hs_seen_q) ? hwcnt_q : hs_width_q;
    hw_vld_d      = hw_vld_q | (hs_fall & hs_seen_q);
    lcnt_d        = lcnt_q;
    // a coincident hs edge belongs to the new frame
    if (vs_rise)                     lcnt_d = {10'd0, hs_rise};
    else if (hs_rise && lcnt_q != '1) lcnt_d = lcnt_q + 11'd1;
    frame_lines_d = vs_rise ? lcnt_q : frame_lines_q;
    vcnt_d        = vcnt_q;
    if (vs_rise)                            vcnt_d = {10'd0, hs_rise};
    else if (vs_a && hs_rise && vcnt_q != '1) vcnt_d = vcnt_q + 11'd1;
    vs_width_d    = (vs_fall & vs_seen_q) ? vcnt_q : vs_width_q;
    acc_d         = vs_rise ? {12'd0, r, g, b} : acc_q + {12'd0, r, g, b};
    checksum_d    = vs_rise ? acc_q : checksum_q;
    err_h_d       = err_h_q | h_mis;
    err_v_d       = err_v_q | v_mis;
  end

  // Lock FSM: counts consecutive clean frames, drops out on any mismatch
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    bad_d   = bad_q;
    fd_d    = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = MEASURE;
          match_d = '0;
          bad_d   = 1'b0;
        end
      end
      MEASURE: begin
        fd_d = vs_rise;
        if (vs_rise) begin
          if (!bad_q && !v_mis && !h_mis) begin
            match_d = match_q + 4'd1;
            if ({1'b0, match_q} + 5'd1 >= LOCK_C) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
          bad_d = h_mis;
        end else if (h_mis) begin
          match_d = '0;
          bad_d   = 1'b1;
        end
      end
      LOCKED: begin
        fd_d = vs_rise;
        if (h_mis || v_mis) begin
          state_d = MEASURE;
          match_d = '0;
          // a failed frame end leaves the new frame clean unless hs also failed
          bad_d   = vs_rise ? h_mis : 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hs_seen_q     <= 1'b0;
      vs_seen_q     <= 1'b0;
      hw_vld_q      <= 1'b0;
      hcnt_q        <= '0;
      hwcnt_q       <= '0;
      line_len_q    <= '0;
      hs_width_q    <= '0;
      lcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_lines_q <= '0;
      vs_width_q    <= '0;
      acc_q         <= '0;
      checksum_q    <= '0;
      match_q       <= '0;
      bad_q         <= 1'b0;
      fd_q          <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_a;
      vs_prev_q     <= vs_a;
      hs_seen_q     <= hs_seen_d;
      vs_seen_q     <= vs_seen_d;
      hw_vld_q      <= hw_vld_d;
      hcnt_q        <= hcnt_d;
      hwcnt_q       <= hwcnt_d;
      line_len_q    <= line_len_d;
      hs_width_q    <= hs_width_d;
      lcnt_q        <= lcnt_d;
      vcnt_q        <= vcnt_d;
      frame_lines_q <= frame_lines_d;
      vs_width_q    <= vs_width_d;
      acc_q         <= acc_d;
      checksum_q    <= checksum_d;
      match_q       <= match_d;
      bad_q         <= bad_d;
      fd_q          <= fd_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
    end
  end

  assign line_len    = line_len_q;
  assign hs_width    = hs_width_q;
  assign frame_lines = frame_lines_q;
  assign vs_width    = vs_width_q;
  assign checksum    = checksum_q;
  assign frame_done  = fd_q;
  assign locked      = (state_q == LOCKED);
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker: drives a scaled-down VGA stream into a
// positive-sync and a negative-sync instance; expected per-frame results are
// queued as each frame is generated and compared on frame_done.
`timescale 1ns/1ps
module tb_vga_frame_checker;
  localparam int HT = 40, VT = 12, HSW = 6, VSW = 3, LOCKN = 2;

  logic clk = 1'b0, rst_n = 1'b0, hs_gen = 1'b0, vs_gen = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;
  logic hs_n, vs_n;
  assign hs_n = ~hs_gen;
  assign vs_n = ~vs_gen;

  logic [11:0] ll0, hw0, ll1, hw1;
  logic [10:0] fl0, vw0, fl1, vw1;
  logic [23:0] cs0, cs1;
  logic fd0, lk0, eh0, ev0, fd1, lk1, eh1, ev1;

  int n_vec = 0, n_err = 0;

  typedef struct {int lines; logic [23:0] csum; bit lk; bit eh; bit ev;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  vga_frame_checker #(.HOR_TOTAL(HT), .VER_TOTAL(VT), .HOR_SYNC_WIDTH(HSW),
    .VER_SYNC_WIDTH(VSW), .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(LOCKN)) u_pos (
    .clk(clk), .rst_n(rst_n), .hs(hs_gen), .vs(vs_gen), .r(r), .g(g), .b(b),
    .line_len(ll0), .hs_width(hw0), .frame_lines(fl0), .vs_width(vw0),
    .checksum(cs0), .frame_done(fd0), .locked(lk0), .err_h(eh0), .err_v(ev0));

  vga_frame_checker #(.HOR_TOTAL(HT), .VER_TOTAL(VT), .HOR_SYNC_WIDTH(HSW),
    .VER_SYNC_WIDTH(VSW), .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(LOCKN)) u_neg (
    .clk(clk), .rst_n(rst_n), .hs(hs_n), .vs(vs_n), .r(r), .g(g), .b(b),
    .line_len(ll1), .hs_width(hw1), .frame_lines(fl1), .vs_width(vw1),
    .checksum(cs1), .frame_done(fd1), .locked(lk1), .err_h(eh1), .err_v(ev1));

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string who, input logic [11:0] ll, input logic [11:0] hw,
                         input logic [10:0] fl, input logic [10:0] vw, input logic [23:0] cs,
                         input logic lk, input logic eh, input logic ev, input exp_t e);
    chk({who, ".line_len"},    ll, HT);
    chk({who, ".hs_width"},    hw, HSW);
    chk({who, ".frame_lines"}, fl, e.lines);
    chk({who, ".vs_width"},    vw, VSW);
    chk({who, ".checksum"},    cs, e.csum);
    chk({who, ".locked"},      lk, e.lk);
    chk({who, ".err_h"},       eh, e.eh);
    chk({who, ".err_v"},       ev, e.ev);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pos.line_len"},    ll0, 0);
    chk({tag, ".pos.hs_width"},    hw0, 0);
    chk({tag, ".pos.frame_lines"}, fl0, 0);
    chk({tag, ".pos.vs_width"},    vw0, 0);
    chk({tag, ".pos.checksum"},    cs0, 0);
    chk({tag, ".pos.flags"},       {fd0, lk0, eh0, ev0}, 0);
    chk({tag, ".neg.all"},         {ll1, hw1, fl1, vw1, cs1, fd1, lk1, eh1, ev1}, 0);
  endtask

  // Scoreboard pop on every frame_done from either instance
  always @(negedge clk) begin
    if (fd0 || fd1) begin
      chk("pos.frame_done", fd0, 1);
      chk("neg.frame_done", fd1, 1);
      chk("sb.pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        cmp_dut("pos", ll0, hw0, fl0, vw0, cs0, lk0, eh0, ev0, mon_e);
        cmp_dut("neg", ll1, hw1, fl1, vw1, cs1, lk1, eh1, ev1, mon_e);
      end
    end
  end

  // Drive lines [l0, lend) of a frame starting at column c0; line 'stretch'
  // is one clock longer. mode 2 = constant white, else random active video.
  task automatic drive_frame(input int l0, input int c0, input int lend, input int stretch,
                             input int mode, input bit push, input bit e_lk,
                             input bit e_eh, input bit e_ev);
    logic [23:0] sum;
    logic [11:0] px;
    int len;
    exp_t e;
    sum = '0;
    for (int l = l0; l < lend; l++) begin
      len = (l == stretch) ? HT + 1 : HT;
      for (int c = (l == l0) ? c0 : 0; c < len; c++) begin
        hs_gen = (c < HSW);
        vs_gen = (l < VSW);
        if (mode == 2) px = 12'hFFF;
        else if (l > VSW && c >= HSW + 2 && c < HT - 2) px = 12'($urandom);
        else px = 12'h000;
        {r, g, b} = px;
        sum = sum + {12'd0, px};
        @(negedge clk);
        if (stretch >= 0 && l == stretch && c == len - 1) begin
          chk("pre_stretch.locked", {lk0, lk1}, 2'b11);
          chk("pre_stretch.err_h",  {eh0, eh1}, 2'b00);
        end
        if (stretch >= 0 && l == stretch + 1 && c == 0) begin
          chk("post_stretch.err_h",  {eh0, eh1}, 2'b11);
          chk("post_stretch.locked", {lk0, lk1}, 2'b00);
        end
      end
    end
    if (push) begin
      e.lines = lend; e.csum = sum; e.lk = e_lk; e.eh = e_eh; e.ev = e_ev;
      sb.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with toggling syncs
    repeat (12) begin
      hs_gen = 1'($urandom); vs_gen = 1'($urandom);
      @(negedge clk);
    end
    check_zero("por");
    rst_n = 1'b1;
    // partial frame starting mid hs pulse: no frame_done expected
    drive_frame(5, 3, VT, -1, 0, 0, 0, 0, 0);
    drive_frame(0, 0, VT, -1, 0, 1, 0, 0, 0);   // A: first clean frame
    drive_frame(0, 0, VT, -1, 0, 1, 1, 0, 0);   // B: second clean -> lock
    drive_frame(0, 0, VT, -1, 0, 1, 1, 0, 0);   // C
    drive_frame(0, 0, VT,  4, 0, 1, 0, 1, 0);   // D: stretched line
    drive_frame(0, 0, VT, -1, 0, 1, 0, 1, 0);   // E
    drive_frame(0, 0, VT, -1, 0, 1, 1, 1, 0);   // F: relocked
    drive_frame(0, 0, VT - 1, -1, 0, 1, 0, 1, 1); // G: one line dropped
    drive_frame(0, 0, VT, -1, 2, 1, 0, 1, 1);   // H: constant white
    drive_frame(0, 0, VT, -1, 0, 1, 1, 1, 1);   // I
    // reset mid-frame
    drive_frame(0, 0, 6, -1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (7) begin
      hs_gen = 1'($urandom); vs_gen = 1'($urandom);
      @(negedge clk);
    end
    check_zero("mid_reset");
    hs_gen = 1'b0; vs_gen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_frame(6, 10, VT, -1, 0, 0, 0, 0, 0);
    drive_frame(0, 0, VT, -1, 0, 1, 0, 0, 0);   // K
    drive_frame(0, 0, VT, -1, 0, 1, 1, 0, 0);   // L: relocked
    drive_frame(0, 0, 2, -1, 0, 0, 0, 0, 0);    // tail to close L
    repeat (3) @(negedge clk);
    chk("sb.drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
